fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage for the MIPS core. Sits directly upstream of the controller and datapath. It owns the PC and fetches from a variable-latency instruction memory through a req/ack handshake. It holds the fetched instruction stable until the datapath signals completion, then computes the next PC from the controller's `pcsrc` and `jump` outputs.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.

- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `pcsrc`  input  1  branch-taken decision from the controller.
- `jump`  input  1  jump decision from the controller.
- `signimm`  input  32  sign-extended immediate of the current instruction.
- `advance`  input  1  datapath pulse: the current instruction has completed.
- `imem_req`  output  1  instruction-memory read request.
- `imem_addr`  output  32  read address; equals `pc`.
- `imem_rdata`  input  32  read data; valid in the cycle `imem_ack`=1.
- `imem_ack`  input  1  one-cycle read-complete pulse.
- `instr`  output  32  held instruction word.
- `instr_valid`  output  1  `instr` is valid for decode and execute.
- `pc`  output  32  address of the held or in-flight instruction.
- `pcplus4`  output  32  `pc + 4`, combinational, modulo 2^32.
- `instret`  output  32  retired-instruction counter.

## Operation
- FSM has three states: IDLE, FETCH, EXEC.
  - IDLE: `imem_req`=0; unconditionally go to FETCH next cycle. IDLE guarantees memory sees req low for at least one cycle after reset.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`, held stable. On `imem_ack`=1: latch `imem_rdata` into `instr`, set `instr_valid`=1, go to EXEC. Otherwise stay.
  - EXEC: `imem_req`=0, `instr` and `instr_valid` held. On `advance`=1, do all of the following, then go to FETCH:
    - load `pc` with next PC;
    - clear `instr_valid`;
    - increment `instret`.
- Next PC is evaluated only on `advance` in EXEC:
  - `jump`=1: `{pcplus4[31:28], instr[25:0], 2'b00}`.
  - `jump`=0 and `pcsrc`=1: `pcplus4 + {signimm[29:0], 2'b00}`.
  - otherwise: `pcplus4`.
  - `jump` has priority over `pcsrc`.
  - All additions are 32-bit, modulo 2^32, and overflow is ignored.
- Ignored inputs:
  - `advance` outside EXEC;
  - `imem_ack` outside FETCH;
  - `pcsrc`, `jump` and `signimm` in any cycle without an accepted `advance`.
- `instret` wraps from `32'hFFFF_FFFF` to 0.
- Reset values:
  - state=IDLE, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `instret`=0, `imem_req`=0.
  - `pcplus4`=`RESET_PC`+4.
- Reset has priority over every input in the same cycle, including an `imem_ack` or `advance` arriving with reset. A read in flight is abandoned; its data is never latched.

## Timing
- Reset asserted in cycle R: cycle R+1 is IDLE, cycle R+2 is FETCH with `imem_req`=1.
- `imem_ack` in cycle N: `instr` and `instr_valid`=1 visible from cycle N+1.
  - Minimum fetch is 1 cycle, because ack is allowed in the first req cycle.
- `advance` in cycle M: from cycle M+1 the block shows the new `pc`, `instr_valid`=0, `imem_req`=1 and `instret`+1.
- Back-to-back rules:
  - At least 1 cycle separates the end of one EXEC from the next `instr_valid`.
  - `advance` held high across the FETCH cycles has no effect.
- `imem_addr` changes only on entry to FETCH or on reset, never while `imem_req`=1.

## Test plan
- Reset with `RESET_PC`=`32'h0040_0000` → `pc`=`0x00400000`, `imem_req` low for one cycle then high with addr `0x00400000`, `instr_valid`=0, `instret`=0.
- Ack `0x20080005` after 2 wait cycles, then `advance` with `pcsrc`=0, `jump`=0 → `instr`=`0x20080005` one cycle after ack; `pc`=`0x00400004`; `instret`=1; new request at `0x00400004`.
- Branch at `pc`=`0x00400004`, `signimm`=`0xFFFFFFFE`, `pcsrc`=1, `advance` → `pc`=`0x00400000`.
- `instr`=`0x08100010` at `pc`=`0x00400000` with `jump`=1 and `pcsrc`=1 (jump priority) → `pc`=`0x00400040`.
- `RESET_PC`=`32'hFFFF_FFFC`, sequential `advance` → `pc`=`0x00000000`, `pcplus4`=`0x00000004`.
- Reset asserted in FETCH while `imem_ack`=1, plus `advance` pulses outside EXEC → no latch (`instr_valid`=0, `instr`=0), `pc`=`RESET_PC`, `instret` unchanged from 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage for the MIPS core.
// Owns the PC, reads instructions from a variable-latency memory over a
// req/ack handshake, holds each instruction until the datapath reports
// completion, then steps the PC (sequential, branch or jump).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] instret
);

  // IDLE only exists to give memory one quiet cycle after reset.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc_next;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        ack_accepted;
  logic        advance_accepted;

  // Handshake inputs only count in the state that listens for them.
  assign ack_accepted     = (state == FETCH) && imem_ack;
  assign advance_accepted = (state == EXEC) && advance;

  // The request is a pure function of state, so the address (the PC) can
  // only move while the request is low.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  assign pcplus4       = pc + 32'd4;
  assign jump_target   = {pcplus4[31:28], instr[25:0], 2'b00};
  // Word offset shifted to bytes; bits shifted out are lost modulo 2^32.
  assign branch_target = pcplus4 + (signimm << 2);

  // Next-PC select: jump outranks a taken branch.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    pc_next = pcplus4;
    if (jump) begin
      pc_next = jump_target;
    end else if (pcsrc) begin
      pc_next = branch_target;
    end
  end

  // FSM transition logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (imem_ack) state_next = EXEC;
      EXEC:    if (advance) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // PC register: only moves when an instruction retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (advance_accepted) begin
      pc <= pc_next;
    end
  end

  // Instruction holding register and its valid flag. The word itself is kept
  // after retirement; only the flag drops. A read abandoned by reset is
  // never captured because reset has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else if (ack_accepted) begin
      instr       <= imem_rdata;
      instr_valid <= 1'b1;
    end else if (advance_accepted) begin
      instr_valid <= 1'b0;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= 32'h0;
    end else if (advance_accepted) begin
      instret <= instret + 32'd1;
    end
  end

endmodule
